// File: rtl/uart_pkg.sv
// Shared definitions for the main-link dispatcher and the per-channel UART tx stage.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_STOP
   } ser_state_e;

   localparam int CLKS_PER_BIT_DEF = 434;

   localparam logic [7:0] FRAME_HDR_B0 = 8'h24;
   localparam logic [7:0] FRAME_HDR_B1 = 8'h43;
   localparam logic [7:0] FRAME_HDR_B2 = 8'h54;
   localparam logic [7:0] FRAME_HDR_B3 = 8'h46;

   function automatic logic [7:0] frame_hdr_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return FRAME_HDR_B0;
         2'd1:    return FRAME_HDR_B1;
         2'd2:    return FRAME_HDR_B2;
         default: return FRAME_HDR_B3;
      endcase
   endfunction

endpackage

// File: rtl/uart_chan_tx_if.sv
// Dispatcher-to-channel byte/frame strobes; the dispatcher is master, the channel is slave.
interface uart_chan_tx_if;
   logic       tx_status;
   logic       tx_over;
   logic [7:0] tx_data;
   logic       tx_data_ready;

   modport master (output tx_status, tx_over, tx_data, tx_data_ready);
   modport slave  (input  tx_status, tx_over, tx_data, tx_data_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 serialiser: accepts a byte (in_dat valid during LOAD) and shifts it out LSB first.
// Start bit begins one cycle after LOAD; in_rdy is high only in LOAD, so the source holds until then.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_vld,
   output logic       in_rdy,
   input  logic [7:0] in_dat,
   output logic       txd,
   output logic       busy
);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   ser_state_e        state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              txd_q, txd_d;
   logic              baud_end;

   assign baud_end = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         ST_IDLE: if (in_vld) state_d = ST_LOAD;
         ST_LOAD: begin
            shift_d = in_dat;
            baud_d  = '0;
            state_d = ST_START;
         end
         ST_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b1, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_STOP;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               state_d = ST_IDLE;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Line level is registered from the next state so uart_txd never glitches on state decode.
      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shift_d[0];
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
      end
   end

   assign in_rdy = (state_q == ST_LOAD);
   assign busy   = (state_q != ST_IDLE);
   assign txd    = txd_q;

endmodule

// File: rtl/uart_chan_tx.sv
// Per-channel store-and-forward frame FIFO feeding an 8N1 serialiser; only committed frames are sent.
// uart_txd falls 2 cycles after the commit edge; no backpressure upstream, writes to a full FIFO are dropped and flagged.
module uart_chan_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int ADDR_W       = 6
) (
   input  logic            clk,
   input  logic            rst,
   uart_chan_tx_if.slave   dsp,
   output logic            uart_txd,
   output logic            tx_busy,
   output logic [ADDR_W:0] fifo_level,
   output logic            frame_drop,
   output logic            overflow
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0] cmt_ptr_q, cmt_ptr_d;
   logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
   logic            frame_ovf_q, frame_ovf_d;
   logic            overflow_q, overflow_d;
   logic            frame_drop_q, frame_drop_d;
   logic            status_q, status_d;
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      rd_dat_q;

   logic full, wr_en, wr_lost, ovf_now, discard;
   logic ser_vld, ser_rdy, ser_busy;

   assign ser_vld = (rd_ptr_q != cmt_ptr_q);

   always_comb begin
      full    = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
      wr_en   = dsp.tx_data_ready & dsp.tx_status & ~full;
      wr_lost = dsp.tx_data_ready & dsp.tx_status & full;
      ovf_now = frame_ovf_q | wr_lost;

      wr_ptr_d     = wr_ptr_q + (ADDR_W+1)'(wr_en);
      cmt_ptr_d    = cmt_ptr_q;
      rd_ptr_d     = rd_ptr_q + (ADDR_W+1)'(ser_vld & ser_rdy);
      frame_ovf_d  = ovf_now;
      overflow_d   = overflow_q | wr_lost;
      frame_drop_d = 1'b0;
      status_d     = dsp.tx_status;
      discard      = 1'b0;

      if (dsp.tx_over) begin
         if (ovf_now) discard = 1'b1;
         else         cmt_ptr_d = wr_ptr_d;
      end else if (status_q & ~dsp.tx_status) begin
         discard = 1'b1;
      end

      // Rolling back an empty, non-overflowed frame discards nothing, so it is not reported.
      if (discard) begin
         wr_ptr_d     = cmt_ptr_q;
         frame_ovf_d  = 1'b0;
         frame_drop_d = (wr_ptr_q != cmt_ptr_q) | ovf_now;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         cmt_ptr_q    <= '0;
         rd_ptr_q     <= '0;
         frame_ovf_q  <= 1'b0;
         overflow_q   <= 1'b0;
         frame_drop_q <= 1'b0;
         status_q     <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         cmt_ptr_q    <= cmt_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         frame_ovf_q  <= frame_ovf_d;
         overflow_q   <= overflow_d;
         frame_drop_q <= frame_drop_d;
         status_q     <= status_d;
      end
   end

   // Dual-port byte store: one write port, one registered read port sampled every cycle.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= dsp.tx_data;
      rd_dat_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
   end

   uart_tx_serializer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clk    (clk),
      .rst    (rst),
      .in_vld (ser_vld),
      .in_rdy (ser_rdy),
      .in_dat (rd_dat_q),
      .txd    (uart_txd),
      .busy   (ser_busy)
   );

   assign tx_busy    = ser_busy | ser_vld;
   assign fifo_level = wr_ptr_q - rd_ptr_q;
   assign frame_drop = frame_drop_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_chan_tx.sv
// Bench for uart_chan_tx with CLKS_PER_BIT=4, depth 8: directed waveforms, a vector table and random frames.
module tb_uart_chan_tx;
   localparam int CPB = 4;
   localparam int AW  = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          uart_txd, tx_busy, frame_drop, overflow;
   logic [AW:0]   fifo_level;

   uart_chan_tx_if dsp_if ();

   uart_chan_tx #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .dsp        (dsp_if),
      .uart_txd   (uart_txd),
      .tx_busy    (tx_busy),
      .fifo_level (fifo_level),
      .frame_drop (frame_drop),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] rx_q  [$];
   logic [7:0] exp_q [$];
   logic [7:0] fb    [$];

   typedef struct {
      logic       s, o, r;
      logic [7:0] d;
      int         lvl;
      logic       drop, ovf;
   } vec_t;
   vec_t tbl [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      tick();
      dsp_if.tx_over       = 1'b0;
      dsp_if.tx_data_ready = 1'b0;
   endtask

   task automatic drive(input logic s, input logic o, input logic r, input logic [7:0] d);
      dsp_if.tx_status     = s;
      dsp_if.tx_over       = o;
      dsp_if.tx_data_ready = r;
      dsp_if.tx_data       = d;
   endtask

   task automatic wr_byte(input logic [7:0] d);
      drive(1'b1, 1'b0, 1'b1, d);
      step();
   endtask

   // tx_over together with tx_status falling: a clean commit that also ends the frame.
   task automatic commit();
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      step();
   endtask

   // Called right after the commit edge; checks every cycle of the expected line waveform.
   task automatic expect_stream(input string nm, input int nb, input logic [23:0] bytes);
      logic [9:0] fr;
      for (int j = 0; j < nb; j++) begin
         for (int c = 0; c < 2; c++) begin
            chk({nm, " idle txd"}, uart_txd, 1);
            if (c == 0) chk({nm, " busy"}, tx_busy, 1);
            tick();
         end
         fr = {1'b1, bytes[8*j +: 8], 1'b0};
         for (int b = 0; b < 10; b++)
            for (int c = 0; c < CPB; c++) begin
               chk({nm, " bit"}, uart_txd, fr[b]);
               tick();
            end
      end
      chk({nm, " end txd"}, uart_txd, 1);
      chk({nm, " end busy"}, tx_busy, 0);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (tx_busy !== 1'b0 && n < 3000) begin
         step();
         n++;
      end
      chk({nm, " idle reached"}, tx_busy, 0);
   endtask

   // Independent line receiver: samples mid-bit and collects decoded bytes.
   int         rx_cnt = 0;
   logic       rx_act = 1'b0;
   logic       prev_txd = 1'b1;
   logic [7:0] rx_sh = '0;
   always @(negedge clk) begin
      if (rst) begin
         rx_act = 1'b0;
      end else if (!rx_act) begin
         if (prev_txd === 1'b1 && uart_txd === 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt >= CPB/2 && ((rx_cnt - CPB/2) % CPB) == 0) begin
            int i;
            i = (rx_cnt - CPB/2) / CPB;
            if (i == 0) chk("rx start bit", uart_txd, 0);
            else if (i <= 8) rx_sh[i-1] = uart_txd;
            else begin
               chk("rx stop bit", uart_txd, 1);
               rx_q.push_back(rx_sh);
               rx_act = 1'b0;
            end
         end
      end
      prev_txd = uart_txd;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int len, mode, gap, lows;
      logic [7:0] d;

      drive(1'b0, 1'b0, 1'b0, 8'h00);
      rst = 1'b1;
      repeat (3) tick();
      chk("reset txd", uart_txd, 1);
      chk("reset busy", tx_busy, 0);
      chk("reset level", fifo_level, 0);
      chk("reset frame_drop", frame_drop, 0);
      chk("reset overflow", overflow, 0);
      rst = 1'b0;
      step();

      // Two bytes then commit: exact waveform, 2-cycle gap, busy drops after last stop.
      wr_byte(8'h55);
      wr_byte(8'hA3);
      commit();
      expect_stream("two_bytes", 2, {8'h00, 8'hA3, 8'h55});

      // Last write coincident with tx_over.
      wr_byte(8'h01);
      drive(1'b1, 1'b1, 1'b1, 8'h02);
      step();
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      fork
         expect_stream("coincident", 2, {8'h00, 8'h02, 8'h01});
         step();
      join

      // Second frame written and committed while the first is on the line.
      wr_byte(8'h11);
      wr_byte(8'h22);
      commit();
      fork
         expect_stream("overlap", 3, {8'h33, 8'h22, 8'h11});
         begin
            repeat (10) step();
            wr_byte(8'h33);
            commit();
         end
      join

      // Abort (drop tx_status) and overflow frames, one vector per cycle.
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 8'h01, 1, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 8'h02, 2, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 8'h03, 3, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0});
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b1, 8'hFF, 0, 1'b0, 1'b0});
      for (int i = 0; i < 10; i++)
         tbl.push_back(vec_t'{1'b1, 1'b0, 1'b1, 8'(i + 16), (i < 8) ? i + 1 : 8, 1'b0, (i >= 8)});
      tbl.push_back(vec_t'{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b1});
      tbl.push_back(vec_t'{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1});
      foreach (tbl[i]) begin
         drive(tbl[i].s, tbl[i].o, tbl[i].r, tbl[i].d);
         step();
         chk("vec level", fifo_level, tbl[i].lvl);
         chk("vec frame_drop", frame_drop, tbl[i].drop);
         chk("vec overflow", overflow, tbl[i].ovf);
         chk("vec txd", uart_txd, 1);
         chk("vec busy", tx_busy, 0);
      end

      // Reset while a byte is in its data bits with two more committed.
      wr_byte(8'hA5);
      wr_byte(8'h3C);
      wr_byte(8'h0F);
      commit();
      repeat (12) step();
      rst = 1'b1;
      step();
      chk("rst txd", uart_txd, 1);
      chk("rst level", fifo_level, 0);
      chk("rst overflow", overflow, 0);
      chk("rst busy", tx_busy, 0);
      rst = 1'b0;
      lows = 0;
      repeat (100) begin
         step();
         if (uart_txd !== 1'b1 || tx_busy !== 1'b0) lows++;
      end
      chk("rst quiet cycles", lows, 0);

      // Random frames against a committed-byte queue model.
      rx_q.delete();
      exp_q.delete();
      for (int f = 0; f < 16; f++) begin
         wait_idle("rnd");
         if ($urandom_range(0, 3) == 0) begin
            drive(1'b0, 1'b0, 1'b1, 8'($urandom));
            step();
            chk("rnd ignored write", fifo_level, 0);
         end
         if ($urandom_range(0, 3) == 0) begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            step();
            chk("rnd empty commit busy", tx_busy, 0);
         end
         len  = $urandom_range(1, 8);
         mode = $urandom_range(0, 5);
         fb.delete();
         for (int i = 0; i < len; i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
               drive(1'b1, 1'b0, 1'b0, 8'h00);
               step();
            end
            d = 8'($urandom);
            fb.push_back(d);
            drive(1'b1, (mode == 1 && i == len - 1), 1'b1, d);
            step();
            chk("rnd level", fifo_level, i + 1);
         end
         if (mode == 0) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00);
            step();
            chk("rnd abort level", fifo_level, 0);
            chk("rnd abort drop", frame_drop, 1);
         end else begin
            drive(1'b0, 1'b1, 1'b0, 8'h00);
            step();
            chk("rnd commit level", fifo_level, len);
            chk("rnd commit drop", frame_drop, 0);
            foreach (fb[i]) exp_q.push_back(fb[i]);
         end
      end
      wait_idle("rnd final");
      repeat (5) step();
      chk("rnd byte count", rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         chk("rnd byte", rx_q[i], exp_q[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
